// File: rtl/acl2_sample_scheduler.sv
// ACL2 accelerometer link sequencer: power-up configuration writes, periodic X/Y/Z sampling
// and host register access, all sharing one start/done SPI transaction engine.
module acl2_sample_scheduler #(
    parameter int unsigned POWERUP_CYCLES = 625000,
    parameter int unsigned SAMPLE_PERIOD  = 1250000,
    parameter int unsigned TIMEOUT_CYCLES = 4095,
    parameter logic [7:0]  X_ADDR         = 8'h08,
    parameter logic [7:0]  Y_ADDR         = 8'h09,
    parameter logic [7:0]  Z_ADDR         = 8'h0A
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       TXN_START,
    output logic       TXN_WRITE,
    output logic [7:0] TXN_ADDR,
    output logic [7:0] TXN_WDATA,
    input  logic       TXN_BUSY,
    input  logic       TXN_DONE,
    input  logic [7:0] TXN_RDATA,
    input  logic       HOST_REQ,
    input  logic       HOST_WRITE,
    input  logic [7:0] HOST_ADDR,
    input  logic [7:0] HOST_WDATA,
    output logic       HOST_ACK,
    output logic [7:0] HOST_RDATA,
    output logic [7:0] X_DATA,
    output logic [7:0] Y_DATA,
    output logic [7:0] Z_DATA,
    output logic       SAMPLE_VALID,
    output logic       SETUP_DONE,
    output logic       FAULT
);

    localparam int unsigned PwrW = $clog2(POWERUP_CYCLES + 1);
    localparam int unsigned SmpW = $clog2(SAMPLE_PERIOD + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        StPwrWait, StSetupIssue, StSetupWait, StIdle, StRdIssue, StRdWait,
        StHostIssue, StHostWait, StFaulted
    } state_e;

    state_e          state_q;
    logic [PwrW-1:0] pwr_cnt_q;
    logic [SmpW-1:0] smp_cnt_q;
    logic [ToW-1:0]  to_cnt_q;
    logic [2:0]      setup_idx_q;
    logic [1:0]      rd_idx_q;
    logic            sample_pending_q;
    logic            host_write_q;
    logic [7:0]      host_addr_q;
    logic [7:0]      host_wdata_q;
    logic [7:0]      x_shadow_q;
    logic [7:0]      y_shadow_q;

    logic            in_issue;
    logic            in_wait;
    logic            iss_write;
    logic [7:0]      iss_addr;
    logic [7:0]      iss_wdata;

    // {addr, data} of the power-up configuration table
    function automatic logic [15:0] setup_entry(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'h20FA;
            3'd1:    return 16'h2100;
            3'd2:    return 16'h2396;
            3'd3:    return 16'h2400;
            3'd4:    return 16'h251E;
            3'd5:    return 16'h273F;
            3'd6:    return 16'h2D0A;
            default: return 16'h0000;
        endcase
    endfunction

    always_comb begin
        in_issue  = state_q inside {StSetupIssue, StRdIssue, StHostIssue};
        in_wait   = state_q inside {StSetupWait, StRdWait, StHostWait};
        iss_write = 1'b0;
        iss_addr  = 8'h00;
        iss_wdata = 8'h00;
        case (state_q)
            StSetupIssue: begin
                iss_write             = 1'b1;
                {iss_addr, iss_wdata} = setup_entry(setup_idx_q);
            end
            StRdIssue: begin
                case (rd_idx_q)
                    2'd0:    iss_addr = X_ADDR;
                    2'd1:    iss_addr = Y_ADDR;
                    default: iss_addr = Z_ADDR;
                endcase
            end
            StHostIssue: begin
                iss_write = host_write_q;
                iss_addr  = host_addr_q;
                iss_wdata = host_wdata_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q          <= StPwrWait;
            pwr_cnt_q        <= '0;
            smp_cnt_q        <= '0;
            to_cnt_q         <= '0;
            setup_idx_q      <= '0;
            rd_idx_q         <= '0;
            sample_pending_q <= 1'b0;
            host_write_q     <= 1'b0;
            host_addr_q      <= '0;
            host_wdata_q     <= '0;
            x_shadow_q       <= '0;
            y_shadow_q       <= '0;
            TXN_START        <= 1'b0;
            TXN_WRITE        <= 1'b0;
            TXN_ADDR         <= '0;
            TXN_WDATA        <= '0;
            HOST_ACK         <= 1'b0;
            HOST_RDATA       <= '0;
            X_DATA           <= '0;
            Y_DATA           <= '0;
            Z_DATA           <= '0;
            SAMPLE_VALID     <= 1'b0;
            SETUP_DONE       <= 1'b0;
            FAULT            <= 1'b0;
        end else begin
            TXN_START    <= 1'b0;
            HOST_ACK     <= 1'b0;
            SAMPLE_VALID <= 1'b0;

            if (in_issue && !TXN_BUSY) begin
                TXN_START <= 1'b1;
                TXN_WRITE <= iss_write;
                TXN_ADDR  <= iss_addr;
                TXN_WDATA <= iss_wdata;
                to_cnt_q  <= '0;
            end

            if (in_wait && !TXN_DONE) begin
                if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
                    FAULT   <= 1'b1;
                    state_q <= StFaulted;
                end else begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end

            case (state_q)
                StPwrWait: begin
                    if (pwr_cnt_q == PwrW'(POWERUP_CYCLES - 1)) state_q <= StSetupIssue;
                    else pwr_cnt_q <= pwr_cnt_q + 1'b1;
                end
                StSetupIssue: if (!TXN_BUSY) state_q <= StSetupWait;
                StSetupWait: begin
                    if (TXN_DONE) begin
                        if (setup_idx_q == 3'd6) begin
                            SETUP_DONE <= 1'b1;
                            smp_cnt_q  <= '0;
                            state_q    <= StIdle;
                        end else begin
                            setup_idx_q <= setup_idx_q + 3'd1;
                            state_q     <= StSetupIssue;
                        end
                    end
                end
                StIdle: begin
                    // HOST_ACK still high means the host has not yet seen it and dropped REQ
                    if (HOST_REQ && !HOST_ACK) begin
                        host_write_q <= HOST_WRITE;
                        host_addr_q  <= HOST_ADDR;
                        host_wdata_q <= HOST_WDATA;
                        state_q      <= StHostIssue;
                    end else if (sample_pending_q) begin
                        sample_pending_q <= 1'b0;
                        rd_idx_q         <= 2'd0;
                        state_q          <= StRdIssue;
                    end
                end
                StRdIssue:   if (!TXN_BUSY) state_q <= StRdWait;
                StRdWait: begin
                    if (TXN_DONE) begin
                        case (rd_idx_q)
                            2'd0: begin
                                x_shadow_q <= TXN_RDATA;
                                rd_idx_q   <= 2'd1;
                                state_q    <= StRdIssue;
                            end
                            2'd1: begin
                                y_shadow_q <= TXN_RDATA;
                                rd_idx_q   <= 2'd2;
                                state_q    <= StRdIssue;
                            end
                            default: begin
                                X_DATA       <= x_shadow_q;
                                Y_DATA       <= y_shadow_q;
                                Z_DATA       <= TXN_RDATA;
                                SAMPLE_VALID <= 1'b1;
                                state_q      <= StIdle;
                            end
                        endcase
                    end
                end
                StHostIssue: if (!TXN_BUSY) state_q <= StHostWait;
                StHostWait: begin
                    if (TXN_DONE) begin
                        HOST_ACK <= 1'b1;
                        if (!host_write_q) HOST_RDATA <= TXN_RDATA;
                        state_q <= StIdle;
                    end
                end
                default: ;
            endcase

            // Placed after the arbiter so a tick coinciding with a set start is not lost
            if (SETUP_DONE) begin
                if (smp_cnt_q == SmpW'(SAMPLE_PERIOD - 1)) begin
                    smp_cnt_q        <= '0;
                    sample_pending_q <= 1'b1;
                end else begin
                    smp_cnt_q <= smp_cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_acl2_sample_scheduler.sv
// Directed bench for acl2_sample_scheduler with a 5-cycle transaction engine model.
module tb_acl2_sample_scheduler;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       TXN_START, TXN_WRITE;
    logic [7:0] TXN_ADDR, TXN_WDATA;
    logic       TXN_BUSY = 1'b0;
    logic       TXN_DONE = 1'b0;
    logic [7:0] TXN_RDATA = 8'h00;
    logic       HOST_REQ = 1'b0;
    logic       HOST_WRITE = 1'b0;
    logic [7:0] HOST_ADDR = 8'h00;
    logic [7:0] HOST_WDATA = 8'h00;
    logic       HOST_ACK;
    logic [7:0] HOST_RDATA, X_DATA, Y_DATA, Z_DATA;
    logic       SAMPLE_VALID, SETUP_DONE, FAULT;

    acl2_sample_scheduler #(
        .POWERUP_CYCLES(10),
        .SAMPLE_PERIOD (100),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .TXN_START   (TXN_START),
        .TXN_WRITE   (TXN_WRITE),
        .TXN_ADDR    (TXN_ADDR),
        .TXN_WDATA   (TXN_WDATA),
        .TXN_BUSY    (TXN_BUSY),
        .TXN_DONE    (TXN_DONE),
        .TXN_RDATA   (TXN_RDATA),
        .HOST_REQ    (HOST_REQ),
        .HOST_WRITE  (HOST_WRITE),
        .HOST_ADDR   (HOST_ADDR),
        .HOST_WDATA  (HOST_WDATA),
        .HOST_ACK    (HOST_ACK),
        .HOST_RDATA  (HOST_RDATA),
        .X_DATA      (X_DATA),
        .Y_DATA      (Y_DATA),
        .Z_DATA      (Z_DATA),
        .SAMPLE_VALID(SAMPLE_VALID),
        .SETUP_DONE  (SETUP_DONE),
        .FAULT       (FAULT)
    );

    always #4 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [15:0] setup_tbl [7] = '{16'h20FA, 16'h2100, 16'h2396, 16'h2400,
                                   16'h251E, 16'h273F, 16'h2D0A};

    // Engine model: answers 5 cycles after TXN_START unless hung
    bit         eng_hang = 1'b0;
    int         ecnt = 0;
    int         done_cyc = 0;
    logic [7:0] x_v = 8'h11, y_v = 8'h22, z_v = 8'h33;

    always @(negedge CLK) begin
        if (RESET) begin
            TXN_BUSY = 1'b0;
            TXN_DONE = 1'b0;
            ecnt     = 0;
        end else begin
            if (TXN_DONE) begin
                TXN_DONE = 1'b0;
                TXN_BUSY = 1'b0;
            end
            if (ecnt != 0) begin
                ecnt--;
                if (ecnt == 0) begin
                    TXN_DONE = 1'b1;
                    done_cyc = cyc;
                    case (TXN_ADDR)
                        8'h08:   TXN_RDATA = x_v;
                        8'h09:   TXN_RDATA = y_v;
                        8'h0A:   TXN_RDATA = z_v;
                        default: TXN_RDATA = 8'hAD;
                    endcase
                end
            end else if (TXN_START && !eng_hang) begin
                TXN_BUSY = 1'b1;
                ecnt     = 5;
            end
        end
    end

    // Transaction / event log
    logic [7:0] lg_addr [128];
    logic [7:0] lg_wd   [128];
    logic       lg_wr   [128];
    int         lg_cyc  [128];
    int         n_log = 0, rst_starts = 0, sv_cnt = 0, sv_cyc = 0, ack_cnt = 0, ack_cyc = 0;
    int         sd_rise_cyc = 0;
    logic       sd_prev = 1'b0;

    always @(negedge CLK) begin
        if (TXN_START) begin
            if (RESET) rst_starts++;
            if (n_log < 128) begin
                lg_addr[n_log] = TXN_ADDR;
                lg_wd[n_log]   = TXN_WDATA;
                lg_wr[n_log]   = TXN_WRITE;
                lg_cyc[n_log]  = cyc;
                n_log++;
            end
        end
        if (SAMPLE_VALID) begin
            sv_cnt++;
            sv_cyc = cyc;
        end
        if (HOST_ACK) begin
            ack_cnt++;
            ack_cyc = cyc;
        end
        if (SETUP_DONE && !sd_prev) sd_rise_cyc = cyc;
        sd_prev = SETUP_DONE;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    function automatic int counter(input int sel);
        case (sel)
            0:       return n_log;
            1:       return ack_cnt;
            2:       return sv_cnt;
            default: return int'(SETUP_DONE);
        endcase
    endfunction

    task automatic wait_cnt(input string tag, input int sel, input int target, input int bound);
        int k = 0;
        while (counter(sel) < target && k < bound) begin
            tick();
            k++;
        end
        check_eq({tag, " reached"}, 64'(counter(sel) >= target), 64'd1);
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({TXN_START, TXN_WRITE, TXN_ADDR, TXN_WDATA, HOST_ACK, HOST_RDATA,
                    X_DATA, Y_DATA, Z_DATA, SAMPLE_VALID, SETUP_DONE, FAULT});
    endfunction

    task automatic run_setup(input string tag);
        int base = n_log;
        RESET = 1'b0;
        wait_cnt({tag, " setup_done"}, 3, 1, 400);
        check_eq({tag, " setup count"}, 64'(n_log - base), 64'd7);
        for (int i = 0; i < 7; i++)
            check_eq($sformatf("%s setup wr%0d", tag, i),
                     {lg_wr[base+i], lg_addr[base+i], lg_wd[base+i]}, {1'b1, setup_tbl[i]});
        check_eq({tag, " setup_done latency"}, 64'(sd_rise_cyc), 64'(done_cyc + 1));
    endtask

    task automatic check_reads(input string tag, input int b);
        check_eq(tag, {lg_wr[b], lg_addr[b], lg_wr[b+1], lg_addr[b+1], lg_wr[b+2], lg_addr[b+2]},
                 {1'b0, 8'h08, 1'b0, 8'h09, 1'b0, 8'h0A});
    endtask

    initial begin
        int b, s, k;
        RESET = 1'b1;
        repeat (3) tick();
        check_eq("reset outputs", out_vec(), 64'd0);
        run_setup("boot");

        // First sample set
        b = n_log;
        wait_cnt("set1 valid", 2, 1, 300);
        check_eq("set1 xyz", 64'({X_DATA, Y_DATA, Z_DATA}), 64'h112233);
        check_reads("set1 reads", b);
        check_eq("set1 valid latency", 64'(sv_cyc), 64'(done_cyc + 1));
        tick();
        check_eq("set1 valid single", 64'(SAMPLE_VALID), 64'd0);

        // Second set: period spacing
        x_v = 8'h44; y_v = 8'h55; z_v = 8'h66;
        wait_cnt("set2 valid", 2, 2, 300);
        check_eq("set2 xyz", 64'({X_DATA, Y_DATA, Z_DATA}), 64'h445566);
        check_eq("set2 period", 64'(lg_cyc[b+3] - lg_cyc[b]), 64'd100);
        s = lg_cyc[b+3];

        // Host read raised in the same cycle the sample tick becomes pending
        x_v = 8'h77; y_v = 8'h88; z_v = 8'h99;
        k = 0;
        while (cyc < s + 98 && k < 300) begin
            tick();
            k++;
        end
        HOST_WRITE = 1'b0; HOST_ADDR = 8'h00; HOST_REQ = 1'b1;
        b = n_log;
        wait_cnt("host rd ack", 1, 1, 200);
        HOST_REQ = 1'b0;
        check_eq("host rd data", 64'(HOST_RDATA), 64'hAD);
        check_eq("host rd ack latency", 64'(ack_cyc), 64'(done_cyc + 1));
        check_eq("host rd first", {lg_wr[b], lg_addr[b]}, {1'b0, 8'h00});
        wait_cnt("set3 valid", 2, 3, 200);
        check_reads("set3 reads", b + 1);
        check_eq("set3 after ack", 64'(lg_cyc[b+1] > ack_cyc), 64'd1);
        check_eq("set3 xyz", 64'({X_DATA, Y_DATA, Z_DATA}), 64'h778899);

        // Host write raised during the Y read of set 4
        x_v = 8'h01; y_v = 8'h02; z_v = 8'h03;
        b = n_log;
        wait_cnt("set4 y start", 0, b + 2, 300);
        HOST_WRITE = 1'b1; HOST_ADDR = 8'h2D; HOST_WDATA = 8'h02; HOST_REQ = 1'b1;
        wait_cnt("host wr ack", 1, 2, 200);
        HOST_REQ = 1'b0;
        check_eq("set4 valid count", 64'(sv_cnt), 64'd4);
        check_eq("set4 xyz", 64'({X_DATA, Y_DATA, Z_DATA}), 64'h010203);
        check_eq("set4 before host wr", 64'(sv_cyc < lg_cyc[b+3]), 64'd1);
        check_eq("host wr txn", {lg_wr[b+3], lg_addr[b+3], lg_wd[b+3]}, {1'b1, 8'h2D, 8'h02});
        check_eq("host wr rdata kept", 64'(HOST_RDATA), 64'hAD);
        check_eq("host wr ack latency", 64'(ack_cyc), 64'(done_cyc + 1));
        check_eq("host wr txn count", 64'(n_log - b), 64'd4);

        // Engine hangs: timeout fault
        eng_hang = 1'b1;
        b = n_log;
        wait_cnt("hang start", 0, b + 1, 300);
        s = lg_cyc[b];
        k = 0;
        while (cyc < s + 49 && k < 100) begin
            tick();
            k++;
        end
        check_eq("fault before timeout", 64'(FAULT), 64'd0);
        tick();
        check_eq("fault at timeout", 64'(FAULT), 64'd1);
        HOST_WRITE = 1'b0; HOST_ADDR = 8'h00; HOST_REQ = 1'b1;
        repeat (300) tick();
        check_eq("faulted no ack", 64'(ack_cnt), 64'd2);
        check_eq("faulted no start", 64'(n_log - b), 64'd1);
        check_eq("fault sticky", 64'(FAULT), 64'd1);
        HOST_REQ = 1'b0;

        // Reset clears the fault and setup repeats
        RESET = 1'b1;
        eng_hang = 1'b0;
        repeat (2) tick();
        check_eq("reset after fault", out_vec(), 64'd0);
        run_setup("post fault");

        // Reset while a sample read is in flight
        b = n_log;
        wait_cnt("abort rd start", 0, b + 1, 300);
        tick();
        tick();
        RESET = 1'b1;
        tick();
        check_eq("reset in rd_wait", out_vec(), 64'd0);
        repeat (4) tick();
        run_setup("post abort");
        check_eq("no start in reset", 64'(rst_starts), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/acl2_sample_scheduler.md
Name: acl2_sample_scheduler

Overview:
Top-level sequencer for the ACL2 accelerometer SPI link. After power-up it issues a fixed 7-entry configuration write table, then periodically schedules X/Y/Z register reads, and arbitrates the single SPI transaction engine between that sampling schedule and a host register-access port. It drives the engine through a one-transaction-at-a-time start/done handshake and publishes the latest 8-bit X/Y/Z samples.

Parameters:
POWERUP_CYCLES, 625000, CLK cycles to wait after reset before the first setup write (5 ms at 125 MHz)
SAMPLE_PERIOD, 1250000, CLK cycles between sample-set starts (100 Hz)
TIMEOUT_CYCLES, 4095, maximum CLK cycles from TXN_START to TXN_DONE before a fault is declared
X_ADDR, 8'h08, X data register; Y_ADDR, 8'h09; Z_ADDR, 8'h0A

Ports:
CLK  in  1  125 MHz system clock
RESET  in  1  synchronous, active-high reset
TXN_START  out  1  one-cycle pulse: engine starts a transaction
TXN_WRITE  out  1  1 = register write (0x0A), 0 = register read (0x0B)
TXN_ADDR  out  8  register address
TXN_WDATA  out  8  write data
TXN_BUSY  in  1  engine busy
TXN_DONE  in  1  one-cycle pulse: transaction complete
TXN_RDATA  in  8  read data, valid only while TXN_DONE=1
HOST_REQ  in  1  host access request, held until HOST_ACK
HOST_WRITE  in  1  host access type
HOST_ADDR  in  8  host address
HOST_WDATA  in  8  host write data
HOST_ACK  out  1  one-cycle pulse when the host transaction completes
HOST_RDATA  out  8  host read result, updated with HOST_ACK
X_DATA, Y_DATA, Z_DATA  out  8 each  latest samples
SAMPLE_VALID  out  1  one-cycle pulse when all three are updated together
SETUP_DONE  out  1  configuration table complete
FAULT  out  1  sticky timeout flag, cleared only by RESET

Behaviour:
- Reset: all outputs 0, state PWR_WAIT, counters 0. RESET asserted mid-transaction aborts immediately; no TXN_START is issued during RESET.
- Setup table, written in order: 20/FA, 21/00, 23/96, 24/00, 25/1E, 27/3F, 2D/0A (addr/data hex).
- States: PWR_WAIT, SETUP_ISSUE, SETUP_WAIT, IDLE, RD_ISSUE, RD_WAIT, HOST_ISSUE, HOST_WAIT, FAULTED.
- PWR_WAIT -> SETUP_ISSUE after POWERUP_CYCLES cycles.
- Any *_ISSUE state: waits for TXN_BUSY=0, then pulses TXN_START for exactly one cycle. TXN_WRITE, TXN_ADDR and TXN_WDATA are valid in that cycle and held stable until TXN_DONE. Next state is the matching *_WAIT.
- Any *_WAIT state: on TXN_DONE, advance. Timeout counter starts at TXN_START; on reaching TIMEOUT_CYCLES without TXN_DONE, set FAULT=1 and go to FAULTED. FAULTED is terminal until RESET; HOST_REQ is never acknowledged there.
- SETUP_WAIT: after entry 6 completes, SETUP_DONE=1 (stays 1) -> IDLE and the sample timer starts at 0. Otherwise index+1 -> SETUP_ISSUE.
- Sample timer: free-running after SETUP_DONE, wraps at SAMPLE_PERIOD-1 and sets sample_pending. sample_pending is cleared when a set starts. Extra ticks while pending are dropped; there is no queue.
- IDLE arbitration, evaluated every cycle:
  - HOST_REQ has priority over sample_pending.
  - If both arrive in the same cycle, the host is served first and the sample set starts immediately after HOST_ACK.
  - Neither ever preempts an in-flight transaction or a sample set.
- Sample set: reads X_ADDR, Y_ADDR, Z_ADDR back-to-back into shadow registers. X_DATA, Y_DATA and Z_DATA update simultaneously, with SAMPLE_VALID=1, in the cycle after the Z TXN_DONE. A host request arriving mid-set waits for the set to finish.
- Host: HOST_* inputs are captured at grant. HOST_ACK pulses in the cycle after TXN_DONE. HOST_RDATA = TXN_RDATA for reads and is unchanged for writes.
- HOST_REQ before SETUP_DONE is held off (not acked) until setup completes.
- TXN_DONE outside a *_WAIT state is ignored.

Test Plan:
- Reset, POWERUP_CYCLES=10, engine model answers in 5 cycles -> 7 TXN_START pulses with TXN_WRITE=1 and addr/data 20/FA … 2D/0A in order; SETUP_DONE rises after the 7th DONE.
- SAMPLE_PERIOD=100, engine returns 0x11/0x22/0x33 -> X_DATA=11, Y_DATA=22, Z_DATA=33 with a single SAMPLE_VALID pulse; the next set starts 100 cycles after the previous one.
- HOST_REQ read addr 0x00 in the same cycle as a sample tick, engine returns 0xAD -> host read issued first, HOST_ACK with HOST_RDATA=AD, then the X/Y/Z reads.
- HOST_REQ write 2D/02 raised during the Y read -> the set completes, SAMPLE_VALID pulses, then a write with TXN_ADDR=2D and TXN_WDATA=02 is issued, followed by HOST_ACK.
- Engine never returns TXN_DONE, TIMEOUT_CYCLES=50 -> FAULT=1 at 50 cycles after TXN_START; no further TXN_START; HOST_REQ is not acked.
- RESET asserted while in RD_WAIT -> all outputs 0 on the next cycle; the full setup sequence repeats after POWERUP_CYCLES.
